// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter in front of the single shared memory port (port 0 = ifetch, port 1 = LSU).
// Optional macro MEM_ARB_TIMEOUT_EN adds m0_err/m1_err and a WAIT-state response timeout.
module mem_port_arbiter #(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_gnt,
   input  logic          mem_rvalid,
   input  logic [DW-1:0] mem_rdata,
   output logic          mux_sel,
   output logic          busy,
   output logic [1:0]    dbg_state
`ifdef MEM_ARB_TIMEOUT_EN
   ,
   output logic          m0_err,
   output logic          m1_err
`endif
);

   // Handshake: requester holds req and payload stable until its gnt pulse; the payload
   // is captured on that edge. rvalid is a one-cycle completion pulse with no backpressure.
   // On the memory side mem_req is held with stable payload until mem_gnt, and at most one
   // transaction is outstanding.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic   owner, last;
   logic   any_req, win, take, done, tmo, tmo_hit;

   always_comb begin
      any_req = m0_req | m1_req;
      win     = (m0_req && m1_req) ? ~last : m1_req;
   end

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
   logic [CW-1:0] wait_cnt;

   // Counts WAIT cycles; held at zero everywhere else so it is clear on WAIT entry.
   always_ff @(posedge clk) begin
      if (!rstn || state != WAIT)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + CW'(1);
   end

   assign tmo_hit = (wait_cnt == CW'(TIMEOUT_CYC));
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      done      = 1'b0;
      tmo       = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               take      = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               if (mem_rvalid) begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            // A real response wins over a timeout landing on the same cycle.
            if (mem_rvalid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               done      = 1'b1;
               tmo       = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (take) begin
            owner     <= win;
            last      <= win;
            mem_we    <= win ? m1_we    : m0_we;
            mem_addr  <= win ? m1_addr  : m0_addr;
            mem_wdata <= win ? m1_wdata : m0_wdata;
         end
      end
   end

   assign m0_gnt    = take & ~win;
   assign m1_gnt    = take &  win;
   assign m0_rvalid = done & ~owner;
   assign m1_rvalid = done &  owner;
   assign m0_rdata  = tmo ? '0 : mem_rdata;
   assign m1_rdata  = tmo ? '0 : mem_rdata;
   assign mem_req   = (state == REQ);
   assign busy      = (state != IDLE);
   assign mux_sel   = owner;
   assign dbg_state = state;

`ifdef MEM_ARB_TIMEOUT_EN
   assign m0_err = tmo & ~owner;
   assign m1_err = tmo &  owner;
`endif

   a_one_gnt : assert property (@(posedge clk) disable iff (!rstn) !(m0_gnt && m1_gnt));
   a_gnt_idle : assert property (@(posedge clk) disable iff (!rstn) (m0_gnt || m1_gnt) |-> !busy);
   a_req_stable : assert property (@(posedge clk) disable iff (!rstn)
      (mem_req && !mem_gnt) |=> (mem_req && $stable(mem_addr) && $stable(mem_wdata) && $stable(mem_we)));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scenario tasks with an expected-result scoreboard.
// Build with +define+MEM_ARB_TIMEOUT_EN to also exercise the timeout path.
module tb_mem_port_arbiter;

   localparam int AW     = 32;
   localparam int DW     = 32;
   localparam int TO_CYC = 4;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [AW-1:0] m0_addr = '0, m1_addr = '0;
   logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
   logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_gnt = 0, mem_rvalid = 0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mux_sel, busy;
   logic [1:0]    dbg_state;
`ifdef MEM_ARB_TIMEOUT_EN
   logic          m0_err, m1_err;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [DW-1:0] exp_q[$];
   logic [0:0]    gnt_q[$];
   logic [0:0]    own_q[$];

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rstn(rstn),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .mux_sel(mux_sel), .busy(busy), .dbg_state(dbg_state)
`ifdef MEM_ARB_TIMEOUT_EN
      , .m0_err(m0_err), .m1_err(m1_err)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      #1;
      total_cnt++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want 0", mem_req, mem_we, mem_addr, mem_wdata); else pass_cnt++;
      total_cnt++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mux_sel} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, mux_sel}); else pass_cnt++;
      rstn = 1'b1;
      tick();
      #1;
      total_cnt++;
      if (dbg_state !== 2'd0 || busy !== 1'b0) $display("FAIL reset_idle: got state=%0d busy=%b want 0 0", dbg_state, busy); else pass_cnt++;
   endtask

   task automatic test_single_read();
      logic [DW-1:0] e;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
      #1;
      exp_q.push_back(32'hDEAD_BEEF);
      total_cnt++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL rd_gnt: got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt); else pass_cnt++;
      tick();
      m0_req = 1'b0; mem_gnt = 1'b1;
      #1;
      total_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mux_sel !== 1'b0 || busy !== 1'b1)
         $display("FAIL rd_req: got req=%b addr=%h we=%b sel=%b busy=%b want 1 100 0 0 1", mem_req, mem_addr, mem_we, mux_sel, busy);
      else pass_cnt++;
      tick();
      mem_gnt = 1'b0;
      #1;
      total_cnt++;
      if (mem_req !== 1'b0 || dbg_state !== 2'd2 || m0_rvalid !== 1'b0) $display("FAIL rd_wait: got req=%b state=%0d rv=%b want 0 2 0", mem_req, dbg_state, m0_rvalid); else pass_cnt++;
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      e = exp_q.pop_front();
      total_cnt++;
      if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== e) $display("FAIL rd_rvalid: got rv0=%b rv1=%b rdata=%h want 1 0 %h", m0_rvalid, m1_rvalid, m0_rdata, e); else pass_cnt++;
      tick();
      mem_rvalid = 1'b0;
      #1;
      total_cnt++;
      if (busy !== 1'b0 || m0_rvalid !== 1'b0) $display("FAIL rd_done: got busy=%b rv=%b want 0 0", busy, m0_rvalid); else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int gnts, rvs;
      logic [0:0] eo;
      logic [DW-1:0] ed;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      gnt_q.push_back(1'b0); gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'hA0;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hB0;
      gnts = 0; rvs = 0;
      for (int cyc = 0; cyc < 40 && rvs < 4; cyc++) begin
         mem_gnt = mem_req; mem_rvalid = mem_req; mem_rdata = 32'hC000_0000 + cyc;
         ed = 32'hC000_0000 + cyc;
         #1;
         if (m0_gnt || m1_gnt) begin
            total_cnt++;
            if ((m0_gnt && m1_gnt) || busy !== 1'b0 || gnt_q.size() == 0) $display("FAIL rr_gnt_legal: got m0=%b m1=%b busy=%b pending=%0d", m0_gnt, m1_gnt, busy, gnt_q.size());
            else begin
               pass_cnt++;
               eo = gnt_q.pop_front();
               own_q.push_back(eo);
               total_cnt++;
               if (m1_gnt !== eo[0]) $display("FAIL rr_order: got port %0d want %0d", m1_gnt, eo); else pass_cnt++;
            end
            gnts++;
         end
         if (m0_rvalid || m1_rvalid) begin
            eo = (own_q.size() != 0) ? own_q.pop_front() : 1'b0;
            total_cnt++;
            if (m1_rvalid !== eo[0] || m0_rvalid !== ~eo[0] || mux_sel !== eo[0] || (eo[0] ? m1_rdata : m0_rdata) !== ed)
               $display("FAIL rr_rvalid: got rv0=%b rv1=%b sel=%b want port %0d data %h", m0_rvalid, m1_rvalid, mux_sel, eo, ed);
            else pass_cnt++;
            rvs++;
         end
         tick();
         if (gnts >= 4) begin m0_req = 1'b0; m1_req = 1'b0; end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      total_cnt++;
      if (gnts != 4 || rvs != 4) $display("FAIL rr_count: got gnts=%0d rvalids=%0d want 4 4", gnts, rvs); else pass_cnt++;
   endtask

   task automatic test_write_stall();
      int bad;
      bad = 0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_2000; m1_wdata = 32'h1234_5678;
      #1;
      total_cnt++;
      if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) $display("FAIL wr_gnt: got m0=%b m1=%b want 0 1", m0_gnt, m1_gnt); else pass_cnt++;
      tick();
      m1_req = 1'b0; m1_addr = 32'hFFFF_FFFF; m1_wdata = 32'h0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || mem_wdata !== 32'h1234_5678 || mem_we !== 1'b1 || mux_sel !== 1'b1)
            $display("FAIL wr_stall%0d: got req=%b addr=%h wdata=%h we=%b sel=%b", i, mem_req, mem_addr, mem_wdata, mem_we, mux_sel);
         else pass_cnt++;
         if (m0_gnt || m0_rvalid || m1_rvalid) bad++;
         tick();
      end
      mem_gnt = 1'b1;
      #1;
      if (m0_gnt || m0_rvalid || m1_rvalid) bad++;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      #1;
      total_cnt++;
      if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) $display("FAIL wr_ack: got rv0=%b rv1=%b want 0 1", m0_rvalid, m1_rvalid); else pass_cnt++;
      tick();
      mem_rvalid = 1'b0;
      total_cnt++;
      if (bad != 0) $display("FAIL wr_quiet: got %0d stray pulses want 0", bad); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300;
      exp_q.push_back(32'h55AA_55AA);
      tick();
      m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h400; m1_wdata = 32'h0BAD_F00D;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA_55AA;
      #1;
      e = exp_q.pop_front();
      total_cnt++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== e || m1_gnt !== 1'b0) $display("FAIL b2b_same: got rv=%b rdata=%h gnt1=%b want 1 %h 0", m0_rvalid, m0_rdata, m1_gnt, e); else pass_cnt++;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      total_cnt++;
      if (busy !== 1'b0 || m1_gnt !== 1'b1) $display("FAIL b2b_next: got busy=%b gnt1=%b want 0 1", busy, m1_gnt); else pass_cnt++;
      tick();
      m1_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      #1;
      total_cnt++;
      if (m1_rvalid !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'h0BAD_F00D || mux_sel !== 1'b1)
         $display("FAIL b2b_second: got rv1=%b addr=%h wdata=%h sel=%b", m1_rvalid, mem_addr, mem_wdata, mux_sel);
      else pass_cnt++;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] e;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h500; m1_wdata = 32'hFACE_0001;
      tick();
      m1_req = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      #1;
      total_cnt++;
      if (dbg_state !== 2'd2 || mux_sel !== 1'b1) $display("FAIL rst_pre: got state=%0d sel=%b want 2 1", dbg_state, mux_sel); else pass_cnt++;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      #1;
      total_cnt++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, busy, mux_sel, m0_rvalid, m1_rvalid} !== '0)
         $display("FAIL rst_vals: got req=%b we=%b addr=%h wdata=%h busy=%b sel=%b", mem_req, mem_we, mem_addr, mem_wdata, busy, mux_sel);
      else pass_cnt++;
      tick();
      tick();
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      total_cnt++;
      if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_late: got rv0=%b rv1=%b busy=%b want 0 0 0", m0_rvalid, m1_rvalid, busy); else pass_cnt++;
      tick();
      mem_rvalid = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h600;
      exp_q.push_back(32'hCAFE_F00D);
      #1;
      total_cnt++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) $display("FAIL rst_regnt: got m0=%b m1=%b want 1 0", m0_gnt, m1_gnt); else pass_cnt++;
      tick();
      m0_req = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      #1;
      e = exp_q.pop_front();
      total_cnt++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== e || mem_addr !== 32'h600) $display("FAIL rst_after: got rv=%b rdata=%h addr=%h want 1 %h 600", m0_rvalid, m0_rdata, mem_addr, e); else pass_cnt++;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      logic seen;
      seen = 1'b0;
      n = 0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h700;
      tick();
      m0_req = 1'b0; mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 20 && !seen; i++) begin
         #1;
         if (m0_rvalid) begin
            seen = 1'b1;
            n = i;
            total_cnt++;
            if (m0_err !== 1'b1 || m1_err !== 1'b0 || m0_rdata !== '0 || m1_rvalid !== 1'b0)
               $display("FAIL to_pulse: got err0=%b err1=%b rdata=%h rv1=%b want 1 0 0 0", m0_err, m1_err, m0_rdata, m1_rvalid);
            else pass_cnt++;
         end
         tick();
      end
      total_cnt++;
      if (!seen || n != TO_CYC) $display("FAIL to_latency: got seen=%b wait_cycles=%0d want 1 %0d", seen, n, TO_CYC); else pass_cnt++;
      mem_rvalid = 1'b1;
      #1;
      total_cnt++;
      if (busy !== 1'b0 || m0_rvalid !== 1'b0 || m0_err !== 1'b0) $display("FAIL to_stray: got busy=%b rv=%b err=%b want 0 0 0", busy, m0_rvalid, m0_err); else pass_cnt++;
      tick();
      mem_rvalid = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_stall();
      test_back_to_back();
      test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for the single shared memory port of the RISC-V core.
  - Port 0: instruction fetch.
  - Port 1: load/store unit.
- Grants one requester at a time, round-robin, and registers the winner's address, write data and write enable.
- Sequences one outstanding transaction on the memory side.
- Drives mux_sel, the select line of the 32-bit 2:1 data/address muxes that sit in front of the memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT_CYC, 255, maximum cycles in WAIT before an error response. Used only with the optional feature.

Ports:
- clk  input  1  clock; everything is on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- m0_req, m1_req  input  1  request valid; held stable until the matching gnt.
- m0_we, m1_we  input  1  1 = write, 0 = read.
- m0_addr, m1_addr  input  AW  request address.
- m0_wdata, m1_wdata  input  DW  write data.
- m0_gnt, m1_gnt  output  1  one-cycle accept pulse; the payload is captured at this edge.
- m0_rvalid, m1_rvalid  output  1  one-cycle completion pulse; for writes it is the write acknowledge.
- m0_rdata, m1_rdata  output  DW  read data; equals mem_rdata, valid only with rvalid.
- mem_req  output  1  memory request valid.
- mem_we  output  1  registered write enable.
- mem_addr  output  AW  registered address.
- mem_wdata  output  DW  registered write data.
- mem_gnt  input  1  memory accepted mem_req.
- mem_rvalid  input  1  memory completion.
- mem_rdata  input  DW  memory read data.
- mux_sel  output  1  owner index (0/1); drives the shared 2:1 mux select.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset, when rstn=0 at a rising edge:
  - state=IDLE, owner=0, last=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All gnt and rvalid outputs are 0; busy=0; mux_sel=0.
  - Reset mid-transaction abandons the transaction: no rvalid is issued and a late mem_rvalid is ignored.
- States: IDLE, REQ, WAIT.
- IDLE:
  - With only one req high, that port wins.
  - With both req high, the port != last wins (round-robin).
  - Because last resets to 1, port 0 wins the first tie.
  - The winner's gnt is asserted combinationally in the same cycle.
  - At the edge: capture addr/we/wdata into the mem_* registers, owner=winner, last=winner, go to REQ.
  - With no req, stay in IDLE.
- REQ:
  - mem_req=1.
  - If mem_gnt=1 and mem_rvalid=1 in the same cycle: complete (rvalid pulse) and go to IDLE.
  - If only mem_gnt=1: go to WAIT.
  - Otherwise hold in REQ with mem_* stable.
- WAIT:
  - mem_req=0.
  - On mem_rvalid=1: m<owner>_rvalid=1 combinationally in that cycle, then go to IDLE.
- mem_rvalid while in IDLE is ignored.
- mux_sel=owner in all states.
- Latency and throughput:
  - gnt happens in cycle T; mem_req is high from T+1.
  - Minimum request-to-rvalid is 2 cycles: mem_gnt=1 and mem_rvalid=1 at T+1.
  - The next grant comes no earlier than the cycle after rvalid, so throughput is at most 1 transaction per 2 cycles.
- Requests arriving while busy wait; gnt is never asserted outside IDLE.
- At most one gnt is high per cycle.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds output ports m0_err and m1_err, 1 bit each.
  - An 8+ bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without mem_rvalid, the arbiter pulses m<owner>_rvalid and m<owner>_err for one cycle with rdata=0, then returns to IDLE.
  - A later stray mem_rvalid is ignored.
  - mem_rvalid on the same cycle as the timeout takes precedence, and err stays 0.
- When undefined: no counter and no err ports; WAIT holds indefinitely.

Test Plan:
- Reset, then m0 reads 0x0000_0100 with mem_gnt at +1 and mem_rvalid=0xDEADBEEF at +3 -> m0_gnt at T, mem_addr=0x100 and mem_req at T+1, m0_rvalid with rdata=0xDEADBEEF at T+3, mux_sel=0, busy falls at T+4.
- m0_req and m1_req held high for 4 transactions, memory responds with 1-cycle latency -> grant order 0,1,0,1; mux_sel follows; no gnt while busy.
- m1 writes 0x0000_2000 with wdata 0x1234_5678 while mem_gnt is held low 3 cycles -> mem_req stays high and mem_addr/wdata/we stay stable for 3 cycles; m1_rvalid comes after mem_rvalid; m0 gets no pulses.
- mem_gnt and mem_rvalid in the same REQ cycle -> rvalid in that cycle, IDLE next cycle, the next grant possible immediately after.
- rstn=0 during WAIT, then mem_rvalid 2 cycles after release -> no rvalid, all outputs at reset values, the next m0 request is granted normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=4, memory never responds -> m0_rvalid and m0_err pulse after 4 WAIT cycles with rdata=0, state returns to IDLE.
